ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
Initiator-side burst engine that drives the single-port synchronous RAM interface (we/addr/din, dout valid one cycle after addr) on behalf of a client. It accepts a burst command (start address, length, direction), streams write data from the client into RAM, or streams RAM read data back to the client with valid/ready backpressure. It sits between a CPU or DMA client and any sp_ram-family memory instance.

Parameters:
DATA_WIDTH, 32, RAM word width
ADDR_WIDTH, 10, RAM address width; address space is 2^ADDR_WIDTH words
LEN_WIDTH, 8, burst length field width; length 0..2^LEN_WIDTH-1 words

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  burst start word address
cmd_len  in  LEN_WIDTH  number of words
wr_valid  in  1  write data offered
wr_ready  out  1  write beat accepted when wr_valid & wr_ready
wr_data  in  DATA_WIDTH  write data
rd_valid  out  1  read data offered
rd_ready  in  1  client accepts read beat
rd_data  out  DATA_WIDTH  read data
busy  out  1  burst in progress
done  out  1  one-cycle pulse when a burst completes
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_din  out  DATA_WIDTH  RAM write data
mem_dout  in  DATA_WIDTH  RAM read data, valid the cycle after mem_addr is presented with mem_we=0

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: cmd_ready=1, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0, mem_we=0, mem_addr=0, mem_din=0.
- FSM: IDLE, WRITE, READ.
  - IDLE: cmd_ready=1. On accept, latch addr, len and direction.
    - len=0: stay IDLE; done pulses next cycle; no RAM access.
    - Otherwise go to WRITE or READ; busy=1 from the next cycle.
- WRITE:
  - wr_ready=1.
  - mem_we = wr_valid, mem_din = wr_data, mem_addr = current address, all combinational.
  - Each accepted beat increments the address and decrements the remaining count.
  - After the last beat: next cycle IDLE, done=1, busy=0.
  - Stalls (wr_valid=0) insert no writes.
- READ:
  - Issue: mem_we=0, mem_addr = current address.
  - Output buffer is a 2-entry FIFO feeding rd_valid/rd_data. In-flight flag = read issued the previous cycle; its mem_dout is pushed this cycle.
  - Issue rule: issue only when remaining>0 and (occupancy + inflight - pop) < 2, where pop = rd_valid & rd_ready. This sustains 1 word/cycle with rd_ready held high.
  - First rd_valid appears 2 cycles after command accept.
  - rd_data must hold stable while rd_valid & ~rd_ready.
  - Burst completes when the last word is popped: next cycle IDLE, done=1.
- Address arithmetic is modulo 2^ADDR_WIDTH: 2^ADDR_WIDTH-1 wraps to 0.
- cmd_ready = ~busy. A new command may be accepted in the done cycle.
- wr_ready=0 outside WRITE. Write beats in IDLE/READ are ignored.
- Reset mid-burst: immediate return to IDLE, FIFO flushed, in-flight read discarded, no done pulse, no further RAM writes.

Optional Feature:
RAM_MASTER_BOUNDS_CHECK_EN
- Defined:
  - Adds output err (1 bit, reset 0).
  - A command with cmd_addr + cmd_len > 2^ADDR_WIDTH is accepted but performs no RAM access.
  - done and err pulse together the next cycle.
  - Legal bursts behave as above, with err=0.
- Undefined: no err port; bursts wrap modulo 2^ADDR_WIDTH.

Test Plan:
1. Write burst addr=0x010, len=4, data 0xA0..0xA3, wr_valid high → mem_we high 4 consecutive cycles at 0x010..0x013; done pulses 1 cycle after the 4th beat.
2. Read burst addr=0x010, len=4, rd_ready high → rd_data 0xA0..0xA3 on 4 consecutive cycles, first 2 cycles after accept; done after the last pop.
3. Read len=6 with rd_ready toggling 1,0,0,1,... → all 6 words delivered in order, no loss or duplication; rd_data stable during stalls; FIFO never exceeds 2 entries.
4. Write addr=0x3FE, len=3 (ADDR_WIDTH=10) → writes at 0x3FE, 0x3FF, 0x000; with RAM_MASTER_BOUNDS_CHECK_EN, no writes and done=err=1.
5. cmd_len=0 → no mem_we or reads; done pulses the cycle after accept; cmd_ready stays 1.
6. rst_n=0 during the 3rd beat of an 8-word read → next cycle rd_valid=0, busy=0, no done; a following 2-word read returns correct data.

Source files
------------

// File: rtl/ram_burst_master.sv
// Burst engine driving a single-port synchronous RAM (1-cycle read latency) for a valid/ready client.
// Optional `RAM_MASTER_BOUNDS_CHECK_EN adds an err output and refuses bursts that cross the top of memory.
module ram_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
  output logic                  err,
`endif
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [LEN_WIDTH-1:0]   iss_rem_q;
  logic [LEN_WIDTH-1:0]   pop_rem_q;
  logic                   done_q;
  logic                   inflight_q;
  logic [1:0]             cnt_q;
  logic [1:0]             cnt_d;
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [DATA_WIDTH-1:0]  fifo_q [2];

  logic cmd_acc;
  logic wr_acc;
  logic pop;
  logic push;
  logic issue;
  logic len_zero;
  logic oob;

  // A read may be issued only if the word it returns is guaranteed a FIFO slot.
  function automatic logic room_for_issue(input logic [1:0] occ,
                                          input logic       infl,
                                          input logic       popping);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, infl};
    return pending < (3'd2 + {2'b00, popping});
  endfunction

`ifdef RAM_MASTER_BOUNDS_CHECK_EN
  localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  localparam logic [SUM_W-1:0] SPACE = SUM_W'(1) << ADDR_WIDTH;
  logic err_q;

  assign oob = (SUM_W'(cmd_addr) + SUM_W'(cmd_len)) > SPACE;
  assign err = err_q;
`else
  assign oob = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = done_q;
  assign wr_ready  = (state_q == ST_WRITE);
  assign rd_valid  = (cnt_q != 2'd0);
  assign rd_data   = rd_valid ? fifo_q[rd_ptr_q] : '0;

  assign cmd_acc  = cmd_valid & cmd_ready;
  assign wr_acc   = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign push     = inflight_q;
  assign len_zero = (cmd_len == '0);
  assign addr_d   = addr_q + ADDR_WIDTH'(1);
  assign cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  assign issue    = (state_q == ST_READ) && (iss_rem_q != '0) &&
                    room_for_issue(cnt_q, inflight_q, pop);

  // Writes are gated by rst_n so a reset cycle can never commit a stray word.
  assign mem_we   = wr_acc & rst_n;
  assign mem_din  = wr_ready ? wr_data : '0;
  assign mem_addr = (state_q == ST_IDLE) ? '0 : addr_q;

  // Control state: FSM, counters, FIFO pointers and the in-flight read flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      iss_rem_q  <= '0;
      pop_rem_q  <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
      err_q      <= 1'b0;
`endif
      inflight_q <= issue;
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;

      unique case (state_q)
        ST_IDLE: begin
          if (cmd_acc) begin
            addr_q    <= cmd_addr;
            iss_rem_q <= cmd_len;
            pop_rem_q <= cmd_len;
            if (len_zero || oob) begin
              done_q <= 1'b1;
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
              err_q  <= oob;
`endif
            end else begin
              state_q <= cmd_write ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (wr_acc) begin
            addr_q    <= addr_d;
            iss_rem_q <= iss_rem_q - LEN_WIDTH'(1);
            if (iss_rem_q == LEN_WIDTH'(1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_q    <= addr_d;
            iss_rem_q <= iss_rem_q - LEN_WIDTH'(1);
          end
          // The burst ends on the last pop, not the last issue.
          if (pop) begin
            pop_rem_q <= pop_rem_q - LEN_WIDTH'(1);
            if (pop_rem_q == LEN_WIDTH'(1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Data path: RAM read data lands in the FIFO the cycle after its issue.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_dout;
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomized bench for ram_burst_master: RAM model plus a behavioural word-array/burst reference model.
`timescale 1ns/1ps
module tb_ram_burst_master;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int LW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, done;
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
  logic          err;
`endif
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]    ram     [DEPTH];
  logic [DW-1:0]    ref_mem [DEPTH];
  logic [AW+DW-1:0] wlog    [$];

  always #5 clk = ~clk;

  ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
    .err(err),
`endif
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Single-port synchronous RAM, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  // Log of every RAM write actually performed.
  always @(negedge clk) begin
    #2;
    if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_din});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic bit oob_of(input int a, input int n);
    return BOUNDS && ((a + n) > DEPTH);
  endfunction

  task automatic send_cmd(input bit w, input int a, input int n, output logic rdy);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(n);
    #1 rdy = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input int a, input int n, input bit stalls, input bit rnd,
                           input logic [DW-1:0] dbase);
    logic rdy;
    int sent, cyc, w0, idx;
    bit fin, early, nordy, ob;
    logic [DW-1:0] d;
    logic [AW+DW-1:0] exp_q [$];
    w0 = wlog.size();
    ob = oob_of(a, n);
    send_cmd(1'b1, a, n, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL wr_cmd_ready got=%b exp=1", rdy); end
    if (n == 0 || ob) begin
      #1;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++; $display("FAIL wr_null done/busy/wr_ready/cmd_ready got=%b%b%b%b exp=1001",
                        done, busy, wr_ready, cmd_ready);
      end
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
      total++; if (err !== ob) begin bad++; $display("FAIL wr_null_err got=%b exp=%b", err, ob); end
`endif
      @(negedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL wr_null_pulse got=%b exp=0", done); end
      total++; if (wlog.size() != w0) begin
        bad++; $display("FAIL wr_null_nowrite got=%0d exp=0", wlog.size() - w0);
      end
      return;
    end
    sent = 0; cyc = 0; fin = 0; early = 0; nordy = 0;
    while (!fin && cyc < 8 * n + 40) begin
      wr_valid = (sent < n) && (!stalls || ($urandom_range(0, 3) != 0));
      d = rnd ? DW'($urandom) : dbase + DW'(sent);
      wr_data = d;
      #1;
      if (sent == n) begin
        fin = 1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0) begin
          bad++; $display("FAIL wr_done done/busy/wr_ready got=%b%b%b exp=100", done, busy, wr_ready);
        end
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", err); end
`endif
        if (!stalls) begin
          total++; if (cyc != n) begin bad++; $display("FAIL wr_timing done_cycle got=%0d exp=%0d", cyc, n); end
        end
      end else begin
        if (done !== 1'b0) early = 1;
        if (wr_ready !== 1'b1 || busy !== 1'b1) nordy = 1;
        if (wr_valid && wr_ready === 1'b1) begin
          idx = (a + sent) % DEPTH;
          exp_q.push_back({AW'(idx), d});
          ref_mem[idx] = d;
          sent++;
        end
      end
      if (!fin) begin @(negedge clk); cyc++; end
    end
    wr_valid = 1'b0;
    total++; if (!fin) begin bad++; $display("FAIL wr_timeout sent=%0d exp=%0d", sent, n); end
    total++; if (early) begin bad++; $display("FAIL wr_early_done got=1 exp=0"); end
    total++; if (nordy) begin bad++; $display("FAIL wr_ready_busy got=dropped exp=held"); end
    total++;
    if (wlog.size() - w0 != exp_q.size()) begin
      bad++; $display("FAIL wr_count got=%0d exp=%0d", wlog.size() - w0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (wlog[w0 + i] !== exp_q[i]) begin
          bad++; $display("FAIL wr_beat%0d addr/data got=%h exp=%h", i, wlog[w0 + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic run_read(input int a, input int n, input int mode);
    logic rdy;
    int popped, cyc, w0, idx;
    bit fin, early, bad_ctl, held, drop, ob;
    logic [DW-1:0] hd;
    w0 = wlog.size();
    ob = oob_of(a, n);
    send_cmd(1'b0, a, n, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rd_cmd_ready got=%b exp=1", rdy); end
    if (n == 0 || ob) begin
      #1;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++; $display("FAIL rd_null done/busy/rd_valid/cmd_ready got=%b%b%b%b exp=1001",
                        done, busy, rd_valid, cmd_ready);
      end
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
      total++; if (err !== ob) begin bad++; $display("FAIL rd_null_err got=%b exp=%b", err, ob); end
`endif
      @(negedge clk); #1;
      total++;
      if (done !== 1'b0 || rd_valid !== 1'b0) begin
        bad++; $display("FAIL rd_null_after done/rd_valid got=%b%b exp=00", done, rd_valid);
      end
      return;
    end
    popped = 0; cyc = 0; fin = 0; early = 0; bad_ctl = 0; held = 0; drop = 0; hd = '0;
    while (!fin && cyc < 8 * n + 40) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 3 == 2);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = $urandom;
      #1;
      if (popped == n) begin
        fin = 1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
          bad++; $display("FAIL rd_done done/busy/rd_valid got=%b%b%b exp=100", done, busy, rd_valid);
        end
      end else begin
        if (done !== 1'b0) early = 1;
        if (busy !== 1'b1 || wr_ready !== 1'b0 || cmd_ready !== 1'b0) bad_ctl = 1;
        if (rd_valid === 1'b1) begin
          if (held) begin
            total++;
            if (rd_data !== hd) begin bad++; $display("FAIL rd_stable got=%h exp=%h", rd_data, hd); end
          end
          if (rd_ready) begin
            idx = (a + popped) % DEPTH;
            total++;
            if (rd_data !== ref_mem[idx]) begin
              bad++; $display("FAIL rd_data beat=%0d got=%h exp=%h", popped, rd_data, ref_mem[idx]);
            end
            if (mode == 0) begin
              total++;
              if (cyc != popped + 2) begin
                bad++; $display("FAIL rd_latency beat=%0d got_cycle=%0d exp=%0d", popped, cyc, popped + 2);
              end
            end
            popped++;
            held = 0;
          end else begin
            held = 1;
            hd   = rd_data;
          end
        end else if (held) begin
          drop = 1;
        end
      end
      if (!fin) begin @(negedge clk); cyc++; end
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    total++; if (!fin) begin bad++; $display("FAIL rd_timeout popped=%0d exp=%0d", popped, n); end
    total++; if (early) begin bad++; $display("FAIL rd_early_done got=1 exp=0"); end
    total++; if (bad_ctl) begin bad++; $display("FAIL rd_ctl busy/wr_ready/cmd_ready got=wrong exp=1/0/0"); end
    total++; if (drop) begin bad++; $display("FAIL rd_valid_drop got=dropped exp=held"); end
    total++; if (wlog.size() != w0) begin
      bad++; $display("FAIL rd_wrote_ram got=%0d exp=0", wlog.size() - w0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_din !== '0) begin bad++; $display("FAIL rst_mem_din got=%h exp=0", mem_din); end
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_release cmd_ready/busy/done got=%b%b%b exp=100", cmd_ready, busy, done);
    end
  endtask

  task automatic test_zero_len();
    run_write(32'h055, 0, 1'b0, 1'b1, '0);
    run_read(32'h066, 0, 0);
  endtask

  task automatic test_write_basic();
    run_write(32'h010, 4, 1'b0, 1'b0, 32'h0000_00A0);
  endtask

  task automatic test_read_basic();
    run_read(32'h010, 4, 0);
  endtask

  task automatic test_fill();
    for (int base = 0; base < DEPTH; base += 255) begin
      run_write(base, (DEPTH - base > 255) ? 255 : DEPTH - base, 1'($urandom_range(0, 1)), 1'b1, '0);
    end
  endtask

  task automatic test_read_backpressure();
    run_read(32'h100, 6, 1);
    run_read(32'h180, 9, 2);
  endtask

  task automatic test_wrap();
    run_write(32'h3FE, 3, 1'b0, 1'b1, '0);
    run_read(32'h3FE, 3, 0);
  endtask

  task automatic test_reset_mid_burst();
    logic rdy;
    int popped, cyc, w0, idx;
    bit hit;
    w0 = wlog.size();
    send_cmd(1'b0, 32'h200, 8, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rmb_cmd_ready got=%b exp=1", rdy); end
    rd_ready = 1'b1; popped = 0; cyc = 0; hit = 0;
    while (!hit && cyc < 40) begin
      #1;
      if (rd_valid === 1'b1) begin
        if (popped == 2) begin
          hit = 1;
        end else begin
          idx = (32'h200 + popped) % DEPTH;
          total++;
          if (rd_data !== ref_mem[idx]) begin
            bad++; $display("FAIL rmb_data beat=%0d got=%h exp=%h", popped, rd_data, ref_mem[idx]);
          end
          popped++;
        end
      end
      if (hit) rst_n = 1'b0;
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
    #1;
    total++; if (!hit) begin bad++; $display("FAIL rmb_timeout popped=%0d exp=2", popped); end
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rmb_after rd_valid/busy/done/cmd_ready got=%b%b%b%b exp=0001",
                      rd_valid, busy, done, cmd_ready);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL rmb_no_done done/rd_valid got=%b%b exp=00", done, rd_valid);
    end
    total++; if (wlog.size() != w0) begin bad++; $display("FAIL rmb_wrote got=%0d exp=0", wlog.size() - w0); end
    rd_ready = 1'b0;
    run_read(int'($urandom_range(0, DEPTH - 3)), 2, 0);
  endtask

  task automatic test_random();
    int a, n;
    for (int k = 0; k < 16; k++) begin
      a = int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(0, 24));
      if ($urandom_range(0, 1) == 1) run_write(a, n, 1'b1, 1'b1, '0);
      else                           run_read(a, n, 2);
    end
    run_write(DEPTH - 5, 9, 1'b1, 1'b1, '0);
    run_read(DEPTH - 5, 9, 2);
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_write_basic();
    test_read_basic();
    test_fill();
    test_read_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
